auteur_fifo_ctrl: RTL and testbench

- Handshake/occupancy controller that sits directly upstream of, and drives, the unchecked auteur_fifo (no full/empty guards).
- Converts ready/valid on the producer and consumer sides into the FIFO's push/pop/flush strobes.
- Guarantees the FIFO is never pushed when full or popped when empty, and exports occupancy status.
- Carries no data. The data path goes straight from the producer to the FIFO's data input, and from the FIFO's data output to the consumer.

---
 rtl/auteur_fifo_ctrl.sv | 117 +++++++++++
 tb/tb_auteur_fifo_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/auteur_fifo_ctrl.sv
// Handshake/occupancy controller driving an unguarded auteur_fifo: ready/valid to push/pop/flush strobes.
// Optional high-water mark enabled by defining AUTEUR_FIFO_CTRL_HWM_EN.
`timescale 1ns/1ps
module auteur_fifo_ctrl #(
    parameter int DEPTH     = 8,
    parameter int PASS_FULL = 1,
    parameter int AFULL_TH  = DEPTH - 1,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             fifo_push_o,
    output logic             fifo_pop_o,
    output logic             fifo_flush_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             afull_o,
    output logic [CNT_W-1:0] hwm_o
);

    if (DEPTH < 1 || DEPTH > 65536) begin : g_bad_depth
        $error("auteur_fifo_ctrl: DEPTH must lie in 1..65536");
    end

    typedef enum logic [1:0] {ST_FLUSH, ST_EMPTY, ST_PARTIAL, ST_FULL} state_t;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [31:0]      AFULL_C  = 32'(AFULL_TH);
    localparam logic             PASS_ON  = (PASS_FULL != 0);

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;
    logic             rdy_q;
    logic             vld_q;
    logic             full_q;

    function automatic state_t decode_state(input logic [CNT_W-1:0] cnt);
        if (cnt == '0)
            return ST_EMPTY;
        else if (cnt == DEPTH_C)
            return ST_FULL;
        else
            return ST_PARTIAL;
    endfunction

    // Flush overrides every handshake; the pass-through path only exists when full.
    assign ready_o      = !flush_i && (rdy_q || (PASS_ON && full_q && ready_i));
    assign valid_o      = !flush_i && vld_q;
    assign fifo_push_o  = valid_i && ready_o;
    assign fifo_pop_o   = valid_o && ready_i;
    assign fifo_flush_o = flush_i;
    assign count_nxt    = count_q + CNT_W'(fifo_push_o) - CNT_W'(fifo_pop_o);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_FLUSH;
            count_q <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            full_q  <= 1'b0;
        end else if (flush_i) begin
            state_q <= ST_FLUSH;
            count_q <= '0;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            full_q  <= 1'b0;
        end else if (state_q == ST_FLUSH) begin
            state_q <= ST_EMPTY;
            count_q <= '0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= decode_state(count_nxt);
            count_q <= count_nxt;
            rdy_q   <= (count_nxt != DEPTH_C);
            vld_q   <= (count_nxt != '0);
            full_q  <= (count_nxt == DEPTH_C);
        end
    end

    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign afull_o = (32'(count_q) >= AFULL_C);

`ifdef AUTEUR_FIFO_CTRL_HWM_EN
    logic [CNT_W-1:0] hwm_q;

    function automatic logic [CNT_W-1:0] max_cnt(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Tracks the registered count, so it trails count_o by one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            hwm_q <= '0;
        else if (flush_i)
            hwm_q <= '0;
        else
            hwm_q <= max_cnt(hwm_q, count_q);
    end

    assign hwm_o = hwm_q;
`else
    assign hwm_o = '0;
`endif

endmodule

// File: tb/tb_auteur_fifo_ctrl.sv
// Bench for auteur_fifo_ctrl: DEPTH=4 instances with PASS_FULL=1 (u0) and PASS_FULL=0 (u1) on shared stimulus.
`timescale 1ns/1ps
module tb_auteur_fifo_ctrl;

    localparam int DEPTH = 4;
    localparam int AFULL = DEPTH - 1;
`ifdef AUTEUR_FIFO_CTRL_HWM_EN
    localparam bit HWM_ON = 1'b1;
`else
    localparam bit HWM_ON = 1'b0;
`endif

    typedef struct {
        logic rdy, vld, push, pop, fl, emp, full, afull;
        int   cnt, hwm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush_i = 1'b0;
    logic       valid_i = 1'b0;
    logic       ready_i = 1'b0;
    logic [1:0] rdy_w, vld_w, push_w, pop_w, fl_w, emp_w, full_w, afull_w;
    logic [2:0] cnt_w [2];
    logic [2:0] hwm_w [2];

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sbq[$];
    int   m_cnt [2];
    bit   m_fl  [2];
    int   m_hwm [2];

    always #5 clk = ~clk;

    auteur_fifo_ctrl #(.DEPTH(DEPTH), .PASS_FULL(1)) u0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy_w[0]),
        .valid_o(vld_w[0]), .ready_i(ready_i), .fifo_push_o(push_w[0]), .fifo_pop_o(pop_w[0]),
        .fifo_flush_o(fl_w[0]), .count_o(cnt_w[0]), .empty_o(emp_w[0]), .full_o(full_w[0]),
        .afull_o(afull_w[0]), .hwm_o(hwm_w[0])
    );

    auteur_fifo_ctrl #(.DEPTH(DEPTH), .PASS_FULL(0)) u1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(rdy_w[1]),
        .valid_o(vld_w[1]), .ready_i(ready_i), .fifo_push_o(push_w[1]), .fifo_pop_o(pop_w[1]),
        .fifo_flush_o(fl_w[1]), .count_o(cnt_w[1]), .empty_o(emp_w[1]), .full_o(full_w[1]),
        .afull_o(afull_w[1]), .hwm_o(hwm_w[1])
    );

    task automatic check(input string tag, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_dut(input int k, input exp_t e);
        check($sformatf("u%0d.ready_o", k), 32'(rdy_w[k]),   int'(e.rdy));
        check($sformatf("u%0d.valid_o", k), 32'(vld_w[k]),   int'(e.vld));
        check($sformatf("u%0d.push", k),    32'(push_w[k]),  int'(e.push));
        check($sformatf("u%0d.pop", k),     32'(pop_w[k]),   int'(e.pop));
        check($sformatf("u%0d.flush", k),   32'(fl_w[k]),    int'(e.fl));
        check($sformatf("u%0d.count", k),   32'(cnt_w[k]),   e.cnt);
        check($sformatf("u%0d.empty", k),   32'(emp_w[k]),   int'(e.emp));
        check($sformatf("u%0d.full", k),    32'(full_w[k]),  int'(e.full));
        check($sformatf("u%0d.afull", k),   32'(afull_w[k]), int'(e.afull));
        check($sformatf("u%0d.hwm", k),     32'(hwm_w[k]),   e.hwm);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0;
            m_fl[k]  = 1'b1;
            m_hwm[k] = 0;
        end
    endtask

    function automatic exp_t model_exp(input int k, input logic v, input logic r, input logic f);
        exp_t e;
        bit   pf  = (k == 0);
        bit   act = !f && !m_fl[k];
        e.rdy   = act && ((m_cnt[k] != DEPTH) || (pf && r));
        e.vld   = act && (m_cnt[k] != 0);
        e.push  = v && e.rdy;
        e.pop   = e.vld && r;
        e.fl    = f;
        e.cnt   = m_cnt[k];
        e.emp   = (m_cnt[k] == 0);
        e.full  = (m_cnt[k] == DEPTH);
        e.afull = (m_cnt[k] >= AFULL);
        e.hwm   = HWM_ON ? m_hwm[k] : 0;
        return e;
    endfunction

    // One cycle: drive at the falling edge, check 2ns later, advance the model, wait for the next falling edge.
    task automatic step(input logic v, input logic r, input logic f);
        exp_t cur [2];
        exp_t e;
        valid_i = v;
        ready_i = r;
        flush_i = f;
        for (int k = 0; k < 2; k++) begin
            cur[k] = model_exp(k, v, r, f);
            sbq.push_back(cur[k]);
        end
        #2;
        for (int k = 0; k < 2; k++) begin
            e = sbq.pop_front();
            check_dut(k, e);
        end
        for (int k = 0; k < 2; k++) begin
            if (f) begin
                m_cnt[k] = 0;
                m_fl[k]  = 1'b1;
                m_hwm[k] = 0;
            end else if (m_fl[k]) begin
                m_fl[k] = 1'b0;
            end else begin
                if (m_cnt[k] > m_hwm[k]) m_hwm[k] = m_cnt[k];
                m_cnt[k] = m_cnt[k] + int'(cur[k].push) - int'(cur[k].pop);
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string phase);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s.u%0d.ready_o", phase, k), 32'(rdy_w[k]), 0);
            check($sformatf("%s.u%0d.valid_o", phase, k), 32'(vld_w[k]), 0);
            check($sformatf("%s.u%0d.push", phase, k),    32'(push_w[k]), 0);
            check($sformatf("%s.u%0d.pop", phase, k),     32'(pop_w[k]), 0);
            check($sformatf("%s.u%0d.count", phase, k),   32'(cnt_w[k]), 0);
            check($sformatf("%s.u%0d.empty", phase, k),   32'(emp_w[k]), 1);
            check($sformatf("%s.u%0d.full", phase, k),    32'(full_w[k]), 0);
            check($sformatf("%s.u%0d.afull", phase, k),   32'(afull_w[k]), 0);
            check($sformatf("%s.u%0d.hwm", phase, k),     32'(hwm_w[k]), 0);
        end
    endtask

    initial begin
        #2;
        check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Reset guard cycle, then EMPTY.
        step(0, 0, 0);
        step(0, 0, 0);
        // Fill to full; fifth cycle is refused.
        repeat (5) step(1, 0, 0);
        // Push+pop while full: u0 passes through, u1 only pops.
        step(1, 1, 0);
        // Drain, then push and pop attempt while empty.
        repeat (5) step(0, 1, 0);
        step(1, 1, 0);
        step(0, 0, 0);
        // Flush mid-stream at count 3.
        repeat (2) step(1, 0, 0);
        step(1, 1, 1);
        step(1, 1, 0);
        step(1, 1, 0);
        // High-water mark: push 3, pop 2, push 1, then flush.
        step(0, 0, 1);
        step(0, 0, 0);
        repeat (3) step(1, 0, 0);
        repeat (2) step(0, 1, 0);
        step(1, 0, 0);
        repeat (2) step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        // Held flush.
        repeat (3) step(1, 1, 1);
        step(1, 1, 0);
        // Random traffic.
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));

        // Asynchronous reset while count is 2.
        step(0, 0, 1);
        step(0, 0, 0);
        repeat (2) step(1, 0, 0);
        step(0, 0, 0);
        #1 rst = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        #1;
        check_reset_outputs("arst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        check("sb_empty", 32'(sbq.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
